// File: rtl/life_ctrl_pkg.sv
// rtl/life_ctrl_pkg.sv - shared opcodes, FSM states and sizes for the life array sequencer
// Purpose: opcode constants, FSM state encoding, scan chain length and small
//          opcode helper used by life_array_seq_ctrl and life_scan_shifter.
// Ports:   none (package).
package life_ctrl_pkg;

    localparam int CELLS = 16;
    localparam int CNT_W = 5;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_READ = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // READ and SWAP return the array contents captured from the chain tail.
    function automatic logic op_captures(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_SWAP);
    endfunction

endpackage

// File: rtl/life_scan_shifter.sv
// rtl/life_scan_shifter.sv - 16-bit scan pattern shifter with capture register and cycle counter
// Purpose: parallel-in/serial-out pattern register (MSB first) paired with a
//          serial-in/parallel-out capture register, plus a cycle counter that
//          flags the last of CELLS shift cycles.
// Ports:   clk, rst_n      clock, async active-low reset
//          load_i          latch pattern_i, clear capture and counter
//          pattern_i       pattern to shift out
//          shift_i         advance both registers by one bit
//          sin_i           serial bit from chain tail
//          sout_o          serial bit to chain head (pattern MSB)
//          cap_o           captured tail bits, first bit read ends up in MSB
//          done_o          high during the final shift cycle
module life_scan_shifter
    import life_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CELLS-1:0] pattern_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic             sout_o,
    output logic [CELLS-1:0] cap_o,
    output logic             done_o
);

    logic [CELLS-1:0] pat_q, pat_d;
    logic [CELLS-1:0] cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        pat_d = pat_q;
        cap_d = cap_q;
        cnt_d = cnt_q;
        if (load_i) begin
            pat_d = pattern_i;
            cap_d = '0;
            cnt_d = '0;
        end else if (shift_i) begin
            pat_d = {pat_q[CELLS-2:0], 1'b0};
            cap_d = {cap_q[CELLS-2:0], sin_i};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
            cap_q <= '0;
            cnt_q <= '0;
        end else begin
            pat_q <= pat_d;
            cap_q <= cap_d;
            cnt_q <= cnt_d;
        end
    end

    assign sout_o = pat_q[CELLS-1];
    assign cap_o  = cap_q;
    assign done_o = shift_i && (cnt_q == CNT_W'(CELLS - 1));

endmodule

// File: rtl/life_array_seq_ctrl.sv
// rtl/life_array_seq_ctrl.sv - command sequencer for the 4x4 life tile array
// Purpose: accepts LOAD/READ/RUN/SWAP commands, drives the array scan chain
//          and run enable, and returns one response per command.
// Ports:   clk, reset                  clock, async active-low reset
//          cmd_valid/ready/op/pattern/gens   host command handshake
//          halt                        abort an in-progress RUN
//          rsp_valid/ready/pattern/gens      response handshake
//          scan, scan_write_val, scan_write_enb, scan_read_val   scan chain
//          run                         one generation per cycle
module life_array_seq_ctrl
    import life_ctrl_pkg::*;
#(
    parameter int GEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CELLS-1:0] cmd_pattern,
    input  logic [GEN_W-1:0] cmd_gens,
    input  logic             halt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CELLS-1:0] rsp_pattern,
    output logic [GEN_W-1:0] rsp_gens,
    output logic             scan,
    output logic             scan_write_val,
    output logic             scan_write_enb,
    input  logic             scan_read_val,
    output logic             run
);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [GEN_W-1:0] gens_q, gens_d;
    logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;
    logic [GEN_W-1:0] gen_inc;
    logic             accept;
    logic             shift_done;
    logic             sh_sout;
    logic [CELLS-1:0] sh_cap;

    assign accept  = (state_q == ST_IDLE) && cmd_valid;
    assign gen_inc = gen_cnt_q + GEN_W'(1);

    life_scan_shifter u_shifter (
        .clk       (clk),
        .rst_n     (reset),
        .load_i    (accept),
        .pattern_i (cmd_pattern),
        .shift_i   (state_q == ST_SHIFT),
        .sin_i     (scan_read_val),
        .sout_o    (sh_sout),
        .cap_o     (sh_cap),
        .done_o    (shift_done)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        gens_d         = gens_q;
        gen_cnt_d      = gen_cnt_q;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_pattern    = '0;
        rsp_gens       = '0;
        scan           = 1'b0;
        scan_write_val = 1'b0;
        scan_write_enb = 1'b0;
        run            = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    gens_d    = cmd_gens;
                    gen_cnt_d = '0;
                    if (cmd_op != OP_RUN) begin
                        state_d = ST_SHIFT;
                    end else if (cmd_gens == '0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_SHIFT: begin
                scan           = 1'b1;
                scan_write_val = sh_sout;
                // READ recirculates the tail so the array survives the scan.
                scan_write_enb = (op_q != OP_READ);
                if (shift_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RUN: begin
                run       = 1'b1;
                // The generation in a halted cycle still executes, so count it.
                gen_cnt_d = gen_inc;
                if (halt || (gen_inc == gens_q)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid   = 1'b1;
                rsp_pattern = op_captures(op_q) ? sh_cap : '0;
                rsp_gens    = (op_q == OP_RUN) ? gen_cnt_q : '0;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD;
            gens_q    <= '0;
            gen_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            gens_q    <= gens_d;
            gen_cnt_q <= gen_cnt_d;
        end
    end

endmodule
